// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Request, response and ALU signal bundle for alu_share_arbiter.
//            The rsp_zf/rsp_sf signals exist only when ALU_SHARE_CC_EN is defined.
// Revision : 1.0
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [1:0]       req0_fn;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [1:0]       req1_fn;
  logic             rsp0_valid, rsp0_ready;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_of;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_s0, alu_s1;
  logic [WIDTH-1:0] alu_add, alu_and, alu_xor;
  logic             alu_of;
`ifdef ALU_SHARE_CC_EN
  logic             rsp_zf, rsp_sf;
`endif

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fn,
    input  req1_valid, req1_a, req1_b, req1_fn,
    input  rsp0_ready, rsp1_ready,
    input  alu_add, alu_and, alu_xor, alu_of,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_of, alu_a, alu_b, alu_s0, alu_s1
`ifdef ALU_SHARE_CC_EN
    , output rsp_zf, rsp_sf
`endif
  );

  // Requesters plus the external ALU
  modport master (
    output req0_valid, req0_a, req0_b, req0_fn,
    output req1_valid, req1_a, req1_b, req1_fn,
    output rsp0_ready, rsp1_ready,
    output alu_add, alu_and, alu_xor, alu_of,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_of, alu_a, alu_b, alu_s0, alu_s1
`ifdef ALU_SHARE_CC_EN
    , input rsp_zf, rsp_sf
`endif
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one external 64-bit ALU between two
//            requesters. Define ALU_SHARE_CC_EN for rsp_zf/rsp_sf outputs.
// Revision : 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter bit RR_INIT = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_next;
  logic             r_last, r_gnt;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [1:0]       r_fn;
  logic             r_of;
  logic             w_win0, w_win1, w_rdy0, w_rdy1, w_exec;
  logic [WIDTH-1:0] w_result;
`ifdef ALU_SHARE_CC_EN
  logic             r_zf, r_sf;
`endif

  // On a tie the requester that did not win last time is served.
  assign w_win0   = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_win1   = bus.req1_valid & (~bus.req0_valid | ~r_last);
  assign w_exec   = (r_state == S_EXEC);
  assign w_result = bus.alu_add | bus.alu_and | bus.alu_xor;

  always_comb begin
    w_next = r_state;
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy0 = w_win0 & rst_n;
        w_rdy1 = w_win1 & rst_n;
        if (w_rdy0 | w_rdy1) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (r_gnt ? bus.rsp1_ready : bus.rsp0_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= RR_INIT;
      r_gnt    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_fn     <= 2'b00;
      r_result <= '0;
      r_of     <= 1'b0;
`ifdef ALU_SHARE_CC_EN
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_rdy0 | w_rdy1) begin
        r_a    <= w_rdy1 ? bus.req1_a  : bus.req0_a;
        r_b    <= w_rdy1 ? bus.req1_b  : bus.req0_b;
        r_fn   <= w_rdy1 ? bus.req1_fn : bus.req0_fn;
        r_gnt  <= w_rdy1;
        r_last <= w_rdy1;
      end
      if (w_exec) begin
        r_result <= w_result;
        r_of     <= bus.alu_of & ~r_fn[1];
`ifdef ALU_SHARE_CC_EN
        r_zf     <= (w_result == '0);
        r_sf     <= w_result[WIDTH-1];
`endif
      end
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp0_valid = (r_state == S_RESP) & ~r_gnt;
  assign bus.rsp1_valid = (r_state == S_RESP) & r_gnt;
  assign bus.rsp_result = r_result;
  assign bus.rsp_of     = r_of;
  // Operands are held at zero outside EXEC to keep the ALU quiet.
  assign bus.alu_a      = w_exec ? r_a : '0;
  assign bus.alu_b      = w_exec ? r_b : '0;
  assign bus.alu_s0     = w_exec & r_fn[0];
  assign bus.alu_s1     = w_exec & r_fn[1];
`ifdef ALU_SHARE_CC_EN
  assign bus.rsp_zf     = r_zf;
  assign bus.rsp_sf     = r_sf;
`endif
endmodule
`default_nettype wire
